sync_fifo_fl: RTL and testbench
===============================

# sync_fifo_fl

Parametrised synchronous FIFO with exact-cycle status flags, programmable almost-full/almost-empty thresholds, occupancy count, sticky overflow/underflow error flags, synchronous flush, and a selectable first-word-fall-through read mode. It is the standard single-clock buffering element for datapaths in this codebase. It supports any integer depth, not only powers of two, with correct pointer wrap-around.

## Interface
- DATA_W, 8, data word width (≥1)
- DEPTH, 10, number of storage entries (≥2, any integer)
- AF_LVL, DEPTH-2, almost_full asserts when count ≥ AF_LVL (1..DEPTH)
- AE_LVL, 2, almost_empty asserts when count ≤ AE_LVL (0..DEPTH-1)
- FWFT, 0, 0 = registered read mode; 1 = first-word-fall-through mode
- Derived: PTR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1)

Reset and clock: reset rst, asynchronous, active-high; clock clk.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request
- dout  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LVL
- almost_empty  out  1  count ≤ AE_LVL
- count  out  CNT_W  current occupancy
- overflow  out  1  sticky; a write was attempted while full
- underflow  out  1  sticky; a read was attempted while empty

## Operation
- Write acceptance: wr_acc = wr_en & !full & !flush. On wr_acc, mem[wr_ptr] <= din and wr_ptr advances.
- Read acceptance: rd_acc = rd_en & !empty & !flush. On rd_acc, rd_ptr advances.
- Acceptance is judged on the pre-edge flags. Write-while-full is refused even when a read is accepted in the same cycle. Read-while-empty is refused even when a write is accepted in the same cycle.
- Pointer advance: pointer == DEPTH-1 wraps to 0; otherwise it increments by 1.
- count_next = count + wr_acc − rd_acc. When both are accepted, count is unchanged.
- All flags are registered and computed from count_next, so flags and count always agree in the same cycle.
- overflow is set on wr_en & full & !flush. underflow is set on rd_en & empty & !flush. Both are cleared only by rst or flush.
- flush has priority over everything else. It zeroes the pointers and count, sets empty and almost_empty, clears full, almost_full and the error flags, and ignores wr_en/rd_en in that cycle. Memory contents are not cleared.
- FWFT=0:
  - dout is registered and loads mem[rd_ptr] on rd_acc.
  - dout holds its value otherwise, including across flush.
- FWFT=1:
  - dout = mem[rd_ptr] combinationally and is valid whenever empty == 0.
  - rd_acc consumes the shown word.
  - dout is don't-care while empty.

## Timing
- Reset values: dout=0, full=0, empty=1, almost_full=0, almost_empty=1, count=0, overflow=0, underflow=0, both pointers 0. Reset takes effect immediately on rst assertion, including mid-transfer.
- Write-to-flag latency is 1 cycle: after the edge that accepts a write into an empty FIFO, empty=0.
- FWFT=0 read latency: data appears on dout 1 cycle after the accepting edge.
- FWFT=1 read latency: a word written into an empty FIFO is visible on dout in the cycle after the write edge, with no rd_en needed.
- Maximum throughput is 1 write and 1 read per cycle.
- The memory array has no reset.

## Structure
- Shared package fifo_pkg holds:
  - the width helper functions (PTR_W/CNT_W derivation)
  - the pointer-increment-with-wrap function, reused by future async/multi-channel FIFOs
- Sub-module fifo_mem: simple dual-port array with 1 write port and 1 read port. It is parametrised by DATA_W and DEPTH, has no reset, and has a combinational read port. The registered dout stage lives in sync_fifo_fl.

## Test plan
All scenarios use DEPTH=10, DATA_W=8, AF_LVL=8, AE_LVL=2.

1. **Fill and overflow (FWFT=0).** After rst, write 0x01..0x0A on consecutive cycles.
   - almost_empty drops after the 3rd write.
   - almost_full rises after the 8th write.
   - full=1 and count=10 after the 10th write.
   - An 11th write of 0xFF is dropped, overflow=1, and count stays 10.
2. **Drain and underflow (FWFT=0).** From the full state, read 10 times.
   - dout shows 0x01..0x0A, each 1 cycle after its rd_en.
   - empty=1 after the 10th read.
   - An 11th read sets underflow=1, and dout holds 0x0A.
3. **Wrap-around.** Write 7 words, read 7, then write 0x10..0x19 and read all 10.
   - Order is preserved across the wrap from pointer 9 to 0.
   - count is 10 at its peak.
4. **Simultaneous read and write.**
   - At count=5, wr_en+rd_en for 4 cycles leaves count=5, data order intact.
   - At full, both requests: the read is accepted, the write is dropped, overflow=1, count=9.
   - At empty, both requests: the write is accepted, underflow=1, count=1.
5. **Flush and reset.**
   - Flush at count=6 with wr_en=1: the next cycle shows count=0, empty=1, errors cleared, and the write is ignored.
   - rst asserted between clock edges mid-burst forces all reset values immediately.
6. **FWFT=1 mode.**
   - Write 0x55 into an empty FIFO: the next cycle shows empty=0 and dout=0x55 without rd_en.
   - Write 0x66, then rd_en: the next cycle shows dout=0x66.
   - A further rd_en sets empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: width derivation, pointer wrap and
// status-flag decode. Kept width-agnostic (int based) so async and
// multi-channel FIFOs can reuse them unchanged.
package fifo_pkg;

   // Registered status flags, all decoded from the same occupancy value
   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   // Address width for a DEPTH-entry array (never below 1 bit)
   function automatic int calc_ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Counter width able to hold 0..DEPTH inclusive
   function automatic int calc_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer advance with wrap at DEPTH-1; works for non power-of-two depths
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

   // Flag decode from an occupancy value
   function automatic fifo_flags_t calc_flags(input int cnt, input int depth,
                                              input int af_lvl, input int ae_lvl);
      fifo_flags_t f;
      f.full         = (cnt == depth);
      f.empty        = (cnt == 0);
      f.almost_full  = (cnt >= af_lvl);
      f.almost_empty = (cnt <= ae_lvl);
      return f;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one combinational
// read port, no reset. Any output register belongs to the caller.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 10,
   localparam int PTR_W = calc_ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fl.sv
// Single-clock FIFO with registered flags/count, programmable almost
// thresholds, sticky overflow/underflow, synchronous flush and either a
// registered or first-word-fall-through read port.
module sync_fifo_fl
   import fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 10,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = 2,
   parameter int FWFT   = 0,
   localparam int PTR_W = calc_ptr_w(DEPTH),
   localparam int CNT_W = calc_cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1,
                                         almost_full: 1'b0, almost_empty: 1'b1};

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count_nxt;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] mem_rdata;
   fifo_flags_t       flags_q;

   // Acceptance uses the registered (pre-edge) flags; flush blocks both sides
   assign wr_acc = wr_en & ~full  & ~flush;
   assign rd_acc = rd_en & ~empty & ~flush;

   // Next occupancy; flags are decoded from this so they never lag count
   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else begin
         unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
         endcase
      end
   end

   // Pointers, occupancy and registered flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         flags_q <= FLAGS_RST;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_acc) wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
            if (rd_acc) rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
         end
         count   <= count_nxt;
         flags_q <= calc_flags(int'(count_nxt), DEPTH, AF_LVL, AE_LVL);
      end
   end

   assign full         = flags_q.full;
   assign empty        = flags_q.empty;
   assign almost_full  = flags_q.almost_full;
   assign almost_empty = flags_q.almost_empty;

   // Sticky error flags; only rst or flush clears them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & full)  overflow  <= 1'b1;
         if (rd_en & empty) underflow <= 1'b1;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word shown directly; meaningful only while not empty
         assign dout = mem_rdata;
      end else begin : g_reg
         // Registered read data, held across idle cycles and flush
         always_ff @(posedge clk or posedge rst) begin
            if (rst)         dout <= '0;
            else if (rd_acc) dout <= mem_rdata;
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_fl.sv
// Directed bench: a registered-read instance and an FWFT instance share
// the same stimulus; expected values are hand-derived per step.
module tb_sync_fifo_fl;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [DW-1:0] din = '0;

   logic [DW-1:0] dout0, dout1;
   logic          full0, empty0, af0, ae0, ov0, un0;
   logic          full1, empty1, af1, ae1, ov1, un1;
   logic [CW-1:0] count0, count1;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   sync_fifo_fl #(.DATA_W(8), .DEPTH(10), .AF_LVL(8), .AE_LVL(2), .FWFT(0)) u0 (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0),
      .almost_empty(ae0), .count(count0), .overflow(ov0), .underflow(un0));

   sync_fifo_fl #(.DATA_W(8), .DEPTH(10), .AF_LVL(8), .AE_LVL(2), .FWFT(1)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1),
      .almost_empty(ae1), .count(count1), .overflow(ov1), .underflow(un1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests, then land just after the edge
   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
      wr_en = w; din = d; rd_en = r; flush = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_dout", dout0, 0);
      chk("rst_full", full0, 0);
      chk("rst_empty", empty0, 1);
      chk("rst_af", af0, 0);
      chk("rst_ae", ae0, 1);
      chk("rst_count", count0, 0);
      chk("rst_ov", ov0, 0);
      chk("rst_un", un0, 0);

      // 1. Fill and overflow
      for (int i = 1; i <= 10; i++) begin
         cyc(1, 8'(i), 0, 0);
         chk($sformatf("fill_count_%0d", i), count0, i);
         chk($sformatf("fill_ae_%0d", i), ae0, (i <= 2) ? 1 : 0);
         chk($sformatf("fill_af_%0d", i), af0, (i >= 8) ? 1 : 0);
         chk($sformatf("fill_full_%0d", i), full0, (i == 10) ? 1 : 0);
         chk($sformatf("fill_empty_%0d", i), empty0, 0);
      end
      chk("fwft_head_full", dout1, 8'h01);
      cyc(1, 8'hFF, 0, 0);
      chk("ovf_count", count0, 10);
      chk("ovf_flag", ov0, 1);
      chk("ovf_full", full0, 1);

      // 2. Drain and underflow
      for (int i = 1; i <= 10; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk($sformatf("drain_dout_%0d", i), dout0, i);
         chk($sformatf("drain_count_%0d", i), count0, 10 - i);
         if (i < 10) chk($sformatf("drain_fwft_%0d", i), dout1, i + 1);
      end
      chk("drain_empty", empty0, 1);
      cyc(0, 8'h00, 1, 0);
      chk("udf_flag", un0, 1);
      chk("udf_dout_hold", dout0, 8'h0A);
      chk("udf_count", count0, 0);
      chk("udf_ov_sticky", ov0, 1);

      // 3. Wrap-around
      for (int i = 0; i < 7; i++) cyc(1, 8'(8'h20 + i), 0, 0);
      chk("wrap_pre_count", count0, 7);
      for (int i = 0; i < 7; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk($sformatf("wrap_pre_dout_%0d", i), dout0, 8'h20 + i);
      end
      for (int i = 0; i < 10; i++) cyc(1, 8'(8'h10 + i), 0, 0);
      chk("wrap_peak_count", count0, 10);
      chk("wrap_peak_full", full0, 1);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk($sformatf("wrap_dout_%0d", i), dout0, 8'h10 + i);
      end
      chk("wrap_empty", empty0, 1);

      // 4. Simultaneous read/write (start clean)
      cyc(0, 8'h00, 0, 1);
      chk("pre4_ov", ov0, 0);
      chk("pre4_un", un0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h30 + i), 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 8'(8'h35 + i), 1, 0);
         chk($sformatf("rw_count_%0d", i), count0, 5);
         chk($sformatf("rw_dout_%0d", i), dout0, 8'h30 + i);
      end
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h39 + i), 0, 0);
      chk("rw_fill_full", full0, 1);
      chk("rw_fill_ov", ov0, 0);
      cyc(1, 8'hEE, 1, 0);
      chk("rwfull_dout", dout0, 8'h34);
      chk("rwfull_count", count0, 9);
      chk("rwfull_ov", ov0, 1);
      chk("rwfull_full", full0, 0);
      for (int i = 0; i < 9; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk($sformatf("rwfull_drain_%0d", i), dout0, 8'h35 + i);
      end
      chk("rwfull_un_clear", un0, 0);
      cyc(1, 8'h77, 1, 0);
      chk("rwempty_count", count0, 1);
      chk("rwempty_un", un0, 1);
      chk("rwempty_empty", empty0, 0);
      chk("rwempty_dout_hold", dout0, 8'h3D);
      cyc(0, 8'h00, 1, 0);
      chk("rwempty_read", dout0, 8'h77);

      // 5. Flush with a concurrent write, then async reset mid-burst
      for (int i = 0; i < 6; i++) cyc(1, 8'(8'h40 + i), 0, 0);
      chk("fl_pre_count", count0, 6);
      cyc(1, 8'h99, 0, 1);
      chk("fl_count", count0, 0);
      chk("fl_empty", empty0, 1);
      chk("fl_ae", ae0, 1);
      chk("fl_af", af0, 0);
      chk("fl_ov", ov0, 0);
      chk("fl_un", un0, 0);
      chk("fl_dout_hold", dout0, 8'h77);
      cyc(0, 8'h00, 0, 0);
      chk("fl_write_ignored", count0, 0);

      cyc(1, 8'h50, 0, 0);
      cyc(1, 8'h51, 0, 0);
      cyc(1, 8'h52, 1, 0);
      chk("burst_dout", dout0, 8'h50);
      chk("burst_count", count0, 2);
      wr_en = 1'b1; din = 8'h53; rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_dout", dout0, 0);
      chk("arst_count", count0, 0);
      chk("arst_empty", empty0, 1);
      chk("arst_ae", ae0, 1);
      chk("arst_full", full0, 0);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rst = 1'b0;
      chk("arst_hold_count", count0, 0);

      // 6. FWFT instance
      cyc(1, 8'h55, 0, 0);
      chk("fwft_empty", empty1, 0);
      chk("fwft_dout55", dout1, 8'h55);
      cyc(1, 8'h66, 0, 0);
      chk("fwft_head_kept", dout1, 8'h55);
      chk("fwft_count2", count1, 2);
      cyc(0, 8'h00, 1, 0);
      chk("fwft_dout66", dout1, 8'h66);
      chk("fwft_count1", count1, 1);
      cyc(0, 8'h00, 1, 0);
      chk("fwft_empty_end", empty1, 1);
      chk("reg_last_dout", dout0, 8'h66);
      cyc(0, 8'h00, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
